hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks destination registers of outstanding long-latency ops (loads and
//   divides that come back through the completion port). The ID instruction
//   is held for RAW, WAW, load-use and capacity hazards. A redirect from EX
//   flushes IF/ID and ID/EX.
//
//   Optional feature macro: HAZARD_CLR_BYPASS_EN
//     defined   : a register completing this cycle already counts as not
//                 pending, so a dependent stall drops in the completion cycle
//     undefined : only the registered pending state is used, so the stall
//                 drops one cycle after the completion
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   id_valid              ID holds an instruction
//   id_rs1/id_rs2         ID source registers
//   id_rs1_rd/id_rs2_rd   the instruction really reads that source
//   id_rd, id_rd_wr       ID destination register and its write enable
//   id_long               ID instruction is long-latency
//   ex_is_load, ex_rd     short load currently in EX and its destination
//   cmp_valid, cmp_rd     long-op completion and its destination
//   br_taken              branch redirect resolved in EX
//   stall_if, stall_id    hold PC/IF-ID, hold ID and bubble EX
//   flush_id, flush_ex    kill IF/ID, kill ID/EX
//   busy                  some register is pending
//   inflight              number of outstanding long ops (0..4)
module hazard_scoreboard (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_rs1_rd,
   input  logic       id_rs2_rd,
   input  logic [4:0] id_rd,
   input  logic       id_rd_wr,
   input  logic       id_long,
   input  logic       ex_is_load,
   input  logic [4:0] ex_rd,
   input  logic       cmp_valid,
   input  logic [4:0] cmp_rd,
   input  logic       br_taken,
   output logic       stall_if,
   output logic       stall_id,
   output logic       flush_id,
   output logic       flush_ex,
   output logic       busy,
   output logic [2:0] inflight
);

   localparam logic [2:0] MAX_INFLIGHT = 3'd4;

   logic [31:0] pending_q, pending_d;
   logic [2:0]  inflight_q, inflight_d;

   logic cmp_eff;
   logic live1, live2;
   logic pend1, pend2, pend_rd;
   logic cap;
   logic raw, waw, load_use, hazard;
   logic issue, long_issue;

   // A completion with nothing outstanding is stale (e.g. after a reset) and is ignored.
   assign cmp_eff = cmp_valid && (inflight_q != 3'd0);

   assign live1 = id_rs1_rd && (id_rs1 != 5'd0);
   assign live2 = id_rs2_rd && (id_rs2 != 5'd0);

`ifdef HAZARD_CLR_BYPASS_EN
   assign pend1   = pending_q[id_rs1] && !(cmp_eff && (cmp_rd == id_rs1));
   assign pend2   = pending_q[id_rs2] && !(cmp_eff && (cmp_rd == id_rs2));
   assign pend_rd = pending_q[id_rd]  && !(cmp_eff && (cmp_rd == id_rd));
   assign cap     = id_long && (inflight_q == MAX_INFLIGHT) && !cmp_eff;
`else
   // Registered state only: a stall survives the completion cycle itself.
   assign pend1   = pending_q[id_rs1];
   assign pend2   = pending_q[id_rs2];
   assign pend_rd = pending_q[id_rd];
   assign cap     = id_long && (inflight_q == MAX_INFLIGHT);
`endif

   assign raw      = (live1 && pend1) || (live2 && pend2);
   assign waw      = id_rd_wr && (id_rd != 5'd0) && pend_rd;
   assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                     ((live1 && (ex_rd == id_rs1)) || (live2 && (ex_rd == id_rs2)));

   // A redirect overrides any stall: the ID instruction is being flushed anyway.
   assign hazard = id_valid && (raw || waw || load_use || cap) && !br_taken;

   assign issue      = id_valid && !hazard && !br_taken;
   assign long_issue = issue && id_long;

   assign stall_id = rst_n && hazard;
   assign stall_if = rst_n && hazard;
   assign flush_id = rst_n && br_taken;
   assign flush_ex = rst_n && br_taken;
   assign busy     = |pending_q;
   assign inflight = inflight_q;

   always_comb begin
      pending_d = pending_q;
      if (cmp_eff)
         pending_d[cmp_rd] = 1'b0;
      // Set is applied after clear so a same-register set wins.
      if (long_issue && id_rd_wr && (id_rd != 5'd0))
         pending_d[id_rd] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_comb begin
      inflight_d = inflight_q;
      if (long_issue && !cmp_eff) begin
         if (inflight_q != MAX_INFLIGHT)
            inflight_d = inflight_q + 3'd1;
      end else if (!long_issue && cmp_eff) begin
         inflight_d = inflight_q - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q  <= '0;
         inflight_q <= '0;
      end else begin
         pending_q  <= pending_d;
         inflight_q <= inflight_d;
      end
   end

endmodule
